mnist_frame_streamer: RTL
=========================

Name: mnist_frame_streamer

Overview:
- Sits directly upstream of top_mnist.
- Accepts one MNIST sample (784 pixels, then 1 label word) over a valid/ready handshake and buffers it in an internal frame RAM.
- Replays the pixels to top_mnist as one gap-free 784-beat burst, waits for the classification result, then compares it against the stored label.
- Maintains frame, correct and timeout statistics for on-chip accuracy measurement.

Parameters:
- DATAWIDTH, 16: pixel, label and m_data width.
- NUM_PIXELS, 784: pixels per frame.
- ADDR_W, 10: frame RAM address width; must satisfy 2**ADDR_W >= NUM_PIXELS.
- RESULT_W, 32: width of the classifier result (top_mnist out).
- CNT_W, 16: width of the statistics counters.
- TIMEOUT_CYCLES, 4096: result watchdog limit. Used only with MNIST_STREAMER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream word ready
- s_data  in  DATAWIDTH  pixel words 0..783, then the label word
- m_valid  out  1  drives top_mnist input_valid
- m_data  out  DATAWIDTH  drives top_mnist input_val
- res_valid  in  1  from top_mnist out_valid (level signal)
- res_data  in  RESULT_W  from top_mnist out
- done  out  1  one-cycle pulse when a frame is scored
- match  out  1  result == label for the last scored frame
- detected  out  RESULT_W  last captured result
- label  out  DATAWIDTH  label of the last scored frame
- frame_cnt  out  CNT_W  frames scored
- correct_cnt  out  CNT_W  frames with match=1
- timeout_cnt  out  CNT_W  frames that timed out (held 0 when the macro is off)

Behaviour:
- Reset values: all outputs 0 except s_ready; state = FILL. s_ready = 1 from the first clock edge after reset release.
- Reset is asynchronous. Asserting it mid-operation immediately drops m_valid, s_ready and done, and discards the partial frame.
- Transfer rule: a word transfers on a rising edge where s_valid && s_ready.
- FILL:
  - s_ready = 1. Transfer n (n = 0..783) writes RAM[n].
  - Transfer 784 latches the label into an internal register (not the label port) and moves to PRIME.
  - The word counter resets to 0 on leaving FILL.
- PRIME (1 cycle):
  - s_ready = 0. Issues a RAM read of address 0; the RAM is synchronous-read with 1-cycle latency.
- STREAM:
  - m_valid = 1 for exactly NUM_PIXELS consecutive cycles with no bubbles; m_data = RAM[k] on beat k.
  - m_valid rises 2 edges after the label transfer.
  - After beat 783, m_valid = 0 and the block moves to WAIT_RES.
  - m_data = 0 whenever m_valid = 0.
- Result edge detection:
  - res_valid is a level signal and may still be high from the previous frame.
  - A result is captured only on a 0->1 edge of res_valid, tracked with a registered res_valid_q.
  - Edges outside WAIT_RES are ignored.
  - res_valid_q updates in every state, so an edge that occurred during STREAM is not seen later.
- WAIT_RES, on a qualifying edge:
  - detected <= res_data; label <= stored label.
  - match <= (res_data == zero-extended label).
  - frame_cnt += 1; correct_cnt += match.
  - Go to REPORT.
- REPORT (1 cycle): done = 1, then return to FILL.
  - s_ready rises the cycle after done; done and s_ready are never high together.
- Counters saturate at all-ones and do not wrap.
- Frame throughput: 785 fill transfers + 1 prime cycle + 784 stream beats + result latency + 1 report cycle.

Optional Feature:
- Macro: MNIST_STREAMER_TIMEOUT_EN.
- With the macro defined:
  - A WAIT_RES cycle counter starts at 0 on entry.
  - If TIMEOUT_CYCLES cycles pass without a qualifying edge: detected <= all-ones, match <= 0, frame_cnt += 1, timeout_cnt += 1, then go to REPORT (done pulses).
  - An edge on the same cycle the limit is reached wins over the timeout.
- Without the macro: no counter logic; timeout_cnt is tied to 0; WAIT_RES waits indefinitely.

Decomposition:
- Package mnist_stream_pkg: state enum (FILL, PRIME, STREAM, WAIT_RES, REPORT) and localparams FRAME_WORDS = NUM_PIXELS+1 and the default widths.
- One sub-module: mnist_frame_ram, a single-port synchronous RAM (1 write/1 read address, 1-cycle read latency) of depth 2**ADDR_W.
- Control, counters and comparison live in the top module.

Test Plan:
- Fill with pixel k = k[15:0], label 7; model returns 7 about 50 cycles after the last beat -> exactly 784 consecutive m_valid cycles, m_data sequence 0..783, done pulse, match=1, frame_cnt=1, correct_cnt=1.
- Second frame, label 3, model returns 5; res_valid held high from frame 1 and toggled low->high in WAIT_RES -> only one capture, detected=5, match=0, frame_cnt=2, correct_cnt=1.
- s_valid randomly deasserted during FILL (50% duty) -> the burst is still gap-free with the correct pixel order; s_ready=0 throughout PRIME, STREAM and WAIT_RES.
- Assert rst at stream beat 400 -> m_valid low immediately; after release, a full new frame scores normally with counters restarted from 0.
- MNIST_STREAMER_TIMEOUT_EN, TIMEOUT_CYCLES=100, model never responds -> done 100 cycles after WAIT_RES entry, detected=32'hFFFFFFFF, timeout_cnt=1, match=0.
- CNT_W=2 with 5 matching frames -> frame_cnt and correct_cnt saturate at 3.

Source files
------------

// File: rtl/mnist_stream_pkg.sv
// mnist_stream_pkg: shared state encoding and default sizes for the MNIST frame streamer
package mnist_stream_pkg;
  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_NUM_PIXELS = 784;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_RESULT_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int FRAME_WORDS = DEF_NUM_PIXELS + 1;
  typedef enum logic [2:0] {FILL, PRIME, STREAM, WAIT_RES, REPORT} state_e;
endpackage

// File: rtl/mnist_frame_ram.sv
// mnist_frame_ram: single-port frame buffer with synchronous one-cycle read
module mnist_frame_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  // write on demand, read the addressed word every cycle
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: buffers one MNIST frame, replays it gap-free to the classifier and scores the result; MNIST_STREAMER_TIMEOUT_EN adds a result watchdog
module mnist_frame_streamer
  import mnist_stream_pkg::*;
#(
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int NUM_PIXELS     = DEF_NUM_PIXELS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int RESULT_W       = DEF_RESULT_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATAWIDTH-1:0] s_data,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  input  logic                 res_valid,
  input  logic [RESULT_W-1:0]  res_data,
  output logic                 done,
  output logic                 match,
  output logic [RESULT_W-1:0]  detected,
  output logic [DATAWIDTH-1:0] label,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     correct_cnt,
  output logic [CNT_W-1:0]     timeout_cnt
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_PIXELS);
  if ((1 << ADDR_W) < NUM_PIXELS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mnist_frame_streamer: frame RAM too small or watchdog limit invalid");
  end
  state_e st_q, st_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] lbl_q, lbl_d, label_q, label_d, rd;
  logic [RESULT_W-1:0] det_q, det_d;
  logic [CNT_W-1:0] frm_q, frm_d, cor_q, cor_d;
  logic rdy_q, rdy_d, rv_q, match_q, match_d;
  logic xfer, last, res_edge, hit, ok, tmo, we;
  assign xfer = s_valid && rdy_q;
  assign last = cnt_q == LAST;
  assign res_edge = res_valid && !rv_q;
  assign hit = st_q == WAIT_RES && res_edge;
  assign ok = res_data == RESULT_W'(lbl_q);
  assign we = st_q == FILL && xfer && !last;
`ifdef MNIST_STREAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic [CNT_W-1:0] tmc_q;
  assign tmo = st_q == WAIT_RES && to_q == TW'(TIMEOUT_CYCLES - 1) && !res_edge;
  assign timeout_cnt = tmc_q;
  // watchdog counts cycles spent in WAIT_RES and tallies expiries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
      tmc_q <= '0;
    end else begin
      to_q <= (st_q == WAIT_RES) ? to_q + TW'(1) : '0;
      tmc_q <= tmc_q + CNT_W'(tmo && ~&tmc_q);
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_cnt = '0;
`endif
  mnist_frame_ram #(.DW(DATAWIDTH), .AW(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (cnt_q[ADDR_W-1:0]),
    .wdata_i (s_data),
    .rdata_o (rd)
  );
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= FILL;
      cnt_q <= '0;
      lbl_q <= '0;
      label_q <= '0;
      det_q <= '0;
      frm_q <= '0;
      cor_q <= '0;
      rdy_q <= 1'b0;
      rv_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      lbl_q <= lbl_d;
      label_q <= label_d;
      det_q <= det_d;
      frm_q <= frm_d;
      cor_q <= cor_d;
      rdy_q <= rdy_d;
      rv_q <= res_valid;
      match_q <= match_d;
    end
  end
  // next state; s_ready is registered so it follows the state being entered
  always_comb begin
    st_d = st_q;
    case (st_q)
      FILL:     if (xfer && last) st_d = PRIME;
      PRIME:    st_d = STREAM;
      STREAM:   if (last) st_d = WAIT_RES;
      WAIT_RES: if (hit || tmo) st_d = REPORT;
      default:  st_d = FILL;
    endcase
    rdy_d = st_d == FILL;
  end
  // word/beat counter, label latch and scoring; the counter runs one read ahead while streaming
  always_comb begin
    cnt_d = cnt_q;
    lbl_d = lbl_q;
    label_d = label_q;
    det_d = det_q;
    match_d = match_q;
    frm_d = frm_q;
    cor_d = cor_q;
    if (st_q == FILL && xfer) cnt_d = last ? '0 : cnt_q + (ADDR_W+1)'(1);
    if (st_q == FILL && xfer && last) lbl_d = s_data;
    if (st_q == PRIME || st_q == STREAM) cnt_d = last ? '0 : cnt_q + (ADDR_W+1)'(1);
    if (hit || tmo) begin
      det_d = hit ? res_data : '1;
      label_d = lbl_q;
      match_d = hit && ok;
      frm_d = frm_q + CNT_W'(~&frm_q);
      cor_d = cor_q + CNT_W'(hit && ok && ~&cor_q);
    end
  end
  // outputs decoded from state and registers
  always_comb begin
    s_ready = rdy_q;
    m_valid = st_q == STREAM;
    m_data = (st_q == STREAM) ? rd : '0;
    done = st_q == REPORT;
    match = match_q;
    detected = det_q;
    label = label_q;
    frame_cnt = frm_q;
    correct_cnt = cor_q;
  end
endmodule
